// File: rtl/rhd_frame_packer.sv
// Packs per-channel RHD samples (one 16-bit word per MISO stream) into framed words: MAGIC, frame count, then data.
// Latency: MAGIC valid the cycle after the accepting strobe; DATA word 0 the cycle after a strobe accepted in GAP.
// Backpressure: out_ready stalls only the output; upstream is never stalled, and samples that find the buffer busy are dropped and counted.
module rhd_frame_packer #(
    parameter int          NUM_STREAMS  = 32,
    parameter int          LAST_CHANNEL = 34,
    parameter logic [15:0] MAGIC        = 16'hC0DE
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      enable,
    input  logic                      sample_valid,
    input  logic [7:0]                sample_channel,
    input  logic [16*NUM_STREAMS-1:0] sample_data,
    output logic [15:0]               out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic [15:0]               overflow_count,
    output logic                      seq_error,
    output logic [15:0]               frame_count
);

    localparam int             IDX_W    = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STREAMS - 1);
    localparam logic [7:0]     LAST_CH  = 8'(LAST_CHANNEL);

    typedef enum logic [2:0] {SYNC, HDR_MAGIC, HDR_COUNT, DATA, GAP} state_t;

    state_t           state_q, state_d;
    logic [15:0]      hold_q [NUM_STREAMS];
    logic [15:0]      hold_d [NUM_STREAMS];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       exp_q, exp_d;
    // term: the sample currently buffered is the last one of this frame
    logic             term_q, term_d;
    logic [15:0]      fc_q, fc_d;
    logic [15:0]      ovf_q, ovf_d;
    logic             serr_q, serr_d;

    logic sv, hs, fin_hs, ch_ok, load, drop;

    assign overflow_count = ovf_q;
    assign seq_error      = serr_q;
    assign frame_count    = fc_q;

    // State register and all datapath flops; reset discards any buffered sample
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= SYNC;
            idx_q   <= '0;
            exp_q   <= '0;
            term_q  <= 1'b0;
            fc_q    <= '0;
            ovf_q   <= '0;
            serr_q  <= 1'b0;
            for (int k = 0; k < NUM_STREAMS; k++) hold_q[k] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            exp_q   <= exp_d;
            term_q  <= term_d;
            fc_q    <= fc_d;
            ovf_q   <= ovf_d;
            serr_q  <= serr_d;
            for (int k = 0; k < NUM_STREAMS; k++) hold_q[k] <= hold_d[k];
        end
    end

    // Next-state: sample acceptance, drop/overflow accounting and frame sequencing
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        exp_d   = exp_q;
        term_d  = term_q;
        fc_d    = fc_q;
        ovf_d   = ovf_q;
        serr_d  = serr_q;
        for (int k = 0; k < NUM_STREAMS; k++) hold_d[k] = hold_q[k];
        load    = 1'b0;
        drop    = 1'b0;
        sv      = sample_valid && enable;
        hs      = out_valid && out_ready;
        fin_hs  = hs && (state_q == DATA) && (idx_q == LAST_IDX);
        ch_ok   = (sample_channel == exp_q);

        case (state_q)
            SYNC: begin
                if (sv && sample_channel == 8'd0) begin
                    load    = 1'b1;
                    exp_d   = 8'd1;
                    state_d = HDR_MAGIC;
                end
            end
            HDR_MAGIC, HDR_COUNT: begin
                // Buffer still holds the frame's first sample, so anything arriving now is lost
                if (!enable) term_d = 1'b1;
                if (sv) begin
                    drop   = 1'b1;
                    term_d = 1'b1;
                end
                if (hs) begin
                    if (state_q == HDR_MAGIC) begin
                        state_d = HDR_COUNT;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                        fc_d    = fc_q + 16'd1;
                    end
                end
            end
            DATA: begin
                if (hs && !fin_hs) idx_d = idx_q + IDX_W'(1);
                if (fin_hs && term_q) begin
                    // Frame ends on this word; the block is resyncing, so only channel 0 can start a new frame
                    state_d = SYNC;
                    if (sv && sample_channel == 8'd0) begin
                        load    = 1'b1;
                        exp_d   = 8'd1;
                        state_d = HDR_MAGIC;
                    end
                end else begin
                    if (!enable) term_d = 1'b1;
                    if (sv) begin
                        if (term_q) begin
                            drop = 1'b1;
                        end else if (!ch_ok) begin
                            serr_d = 1'b1;
                            term_d = 1'b1;
                        end else if (fin_hs) begin
                            load  = 1'b1;
                            exp_d = exp_q + 8'd1;
                            idx_d = '0;
                        end else begin
                            drop   = 1'b1;
                            term_d = 1'b1;
                        end
                    end
                    if (fin_hs && !load) state_d = term_d ? SYNC : GAP;
                end
            end
            GAP: begin
                if (!enable) begin
                    state_d = SYNC;
                end else if (sv) begin
                    if (ch_ok) begin
                        load    = 1'b1;
                        exp_d   = exp_q + 8'd1;
                        idx_d   = '0;
                        state_d = DATA;
                    end else begin
                        serr_d  = 1'b1;
                        state_d = SYNC;
                    end
                end
            end
            default: state_d = SYNC;
        endcase

        if (load) begin
            for (int k = 0; k < NUM_STREAMS; k++) hold_d[k] = sample_data[16*k +: 16];
            term_d = (sample_channel == LAST_CH);
        end
        if (drop && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
    end

    // Output decode: header words, then buffered stream words; idle states drive zero
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        case (state_q)
            HDR_MAGIC: begin
                out_valid = 1'b1;
                out_data  = MAGIC;
            end
            HDR_COUNT: begin
                out_valid = 1'b1;
                out_data  = fc_q;
            end
            DATA: begin
                out_valid = 1'b1;
                out_data  = hold_q[idx_q];
                out_last  = (idx_q == LAST_IDX) && term_q;
            end
            default: ;
        endcase
    end

endmodule
